// File: rtl/vreg_stream.sv
// Vector register of LANES x ELEM_W elements: masked parallel write, element-wise
// stream fill through in_*, element-wise drain through out_*, full vector on dataout.
module vreg_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n)    q <= '0;
        else if (load) q <= d;
    end
endmodule

module vreg_stream #(
    parameter int ELEM_W = 16,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [ELEM_W*LANES-1:0] datain,
    input  logic                    wea,
    input  logic [LANES-1:0]        lane_mask,
    input  logic [ELEM_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ELEM_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ELEM_W*LANES-1:0] dataout,
    output logic                    full,
    output logic                    empty
);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} state_t;

    state_t                         state, state_nxt;
    logic [IDX_W-1:0]               wr_idx, rd_idx, wr_nxt, rd_nxt;
    logic [LANES-1:0][ELEM_W-1:0]   elem, lane_d;
    logic [LANES-1:0]               lane_ld;
    logic                           in_fire, out_fire, wr_last, rd_last;

    // clear and wea both swallow any handshake presented in the same cycle
    assign in_fire  = in_valid  && in_ready  && !wea && !clear;
    assign out_fire = out_valid && out_ready && !wea && !clear;
    assign wr_last  = (wr_idx == IDX_W'(LANES-1));
    assign rd_last  = (rd_idx == IDX_W'(LANES-1));

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign lane_d[i]  = wea ? datain[i*ELEM_W +: ELEM_W] : in_data;
            assign lane_ld[i] = !clear &&
                                (wea ? lane_mask[i] : (in_fire && wr_idx == IDX_W'(i)));
            vreg_lane #(.W(ELEM_W)) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (lane_ld[i]),
                .d     (lane_d[i]),
                .q     (elem[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            state  <= state_nxt;
            wr_idx <= wr_nxt;
            rd_idx <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_idx;
        rd_nxt    = rd_idx;
        if (clear) begin
            state_nxt = EMPTY;
            wr_nxt    = '0;
            rd_nxt    = '0;
        end else if (wea) begin
            state_nxt = FULL;
            wr_nxt    = '0;
            rd_nxt    = '0;
        end else if (in_fire) begin
            state_nxt = wr_last ? FULL : FILLING;
            wr_nxt    = wr_last ? '0 : wr_idx + IDX_W'(1);
        end else if (out_fire) begin
            state_nxt = rd_last ? EMPTY : DRAINING;
            rd_nxt    = rd_last ? '0 : rd_idx + IDX_W'(1);
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        full      = 1'b0;
        empty     = 1'b0;
        case (state)
            EMPTY:    begin in_ready = 1'b1; empty = 1'b1; end
            FILLING:  in_ready  = 1'b1;
            FULL:     begin out_valid = 1'b1; full = 1'b1; end
            DRAINING: out_valid = 1'b1;
            default:  ;
        endcase
    end

    assign out_data = elem[rd_idx];
    assign dataout  = elem;
endmodule
